// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a short in-order pipeline.
// Detects load-use hazards (one-cycle stall) and taken branches resolved in
// MEM (three-stage squash). It also selects the EX operand forwarding source
// and keeps saturating counters of stall and flush events.
module pipeline_hazard_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] id_rs,
    input  logic       id_uses_rs,
    input  logic [1:0] ex_rd,
    input  logic       ex_wr,
    input  logic       ex_rm,
    input  logic [1:0] mem_rd,
    input  logic       mem_wr,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic [1:0] fwd,
    output logic [1:0] state,
    output logic [7:0] stall_count,
    output logic [7:0] flush_count
);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_STALL = 2'b01;
    localparam logic [1:0] ST_FLUSH = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic [1:0] state_q, state_d;
    logic [1:0] fwd_q, fwd_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic [7:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic ex_match;
    logic mem_match;
    logic take_branch;

    // The ID source register matches a pending write in EX or MEM.
    assign ex_match  = id_uses_rs & ex_wr  & (ex_rd  == id_rs);
    assign mem_match = id_uses_rs & mem_wr & (mem_rd == id_rs);
    assign load_use  = ex_match & ex_rm;

    // A branch is honoured in RUN and STALL; in FLUSH the MEM stage holds a
    // wrong-path instruction, so its branch outcome is meaningless.
    assign take_branch = branch_taken & ((state_q == ST_RUN) | (state_q == ST_STALL));

    // Pipeline enables, flushes and next state from current state and inputs.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_d     = ST_RUN;

        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (take_branch) begin
            // Squash the three younger instructions; PC loads the target.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = ST_FLUSH;
        end else if ((state_q == ST_RUN) && load_use) begin
            // Freeze IF/ID and PC, insert one bubble into EX.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            state_d    = ST_STALL;
        end
    end

    // Forwarding select for the instruction about to enter EX; EX wins over MEM.
    always_comb begin
        fwd_d = FWD_RF;
        if (idex_flush) begin
            fwd_d = FWD_RF;
        end else if (ex_match) begin
            fwd_d = FWD_EX;
        end else if (mem_match) begin
            fwd_d = FWD_MEM;
        end
    end

    // Saturating event counters, stepped on entry into STALL or FLUSH.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q == ST_RUN) && (state_d == ST_STALL) && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
        if ((state_d == ST_FLUSH) && (flush_cnt_q != 8'hFF)) begin
            flush_cnt_d = flush_cnt_q + 8'd1;
        end
    end

    // State, forwarding select and counters; synchronous reset wins.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= ST_RUN;
            fwd_q       <= FWD_RF;
            stall_cnt_q <= 8'd0;
            flush_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            fwd_q       <= fwd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state       = state_q;
    assign fwd         = fwd_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
